// File: rtl/prediction_pkg.sv
// Shared types and constants for the tournament branch predictor.
// The chooser adds its counter type, training direction and global threshold here.
package prediction_pkg;

    localparam int INDEX_LEN   = 4;
    localparam int TABLE_DEPTH = 2 ** INDEX_LEN;

    typedef logic [1:0] chooser_ctr_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } chooser_dir_t;

    localparam chooser_ctr_t CHOOSER_GLOBAL_THRESH = 2'd2;

    // Training only has information when the two components disagreed; move the
    // counter toward whichever component would have been right.
    function automatic chooser_dir_t chooser_train_dir(
        input logic were_equal,
        input logic had_guessed_global,
        input logic resolve_predicted,
        input logic resolve_taken
    );
        logic chosen_right;
        logic global_right;
        chosen_right = (resolve_predicted == resolve_taken);
        global_right = (had_guessed_global == chosen_right);
        if (were_equal) begin
            return NONE;
        end
        return global_right ? INC : DEC;
    endfunction

endpackage

// File: rtl/sat_ctr2_update.sv
// Next-value logic for a 2-bit saturating choice counter.
module sat_ctr2_update
    import prediction_pkg::*;
(
    input  chooser_ctr_t ctr,
    input  chooser_dir_t dir,
    output chooser_ctr_t next_ctr
);

    always_comb begin
        // NOTE: default assigned first so every path drives next_ctr and no latch is inferred.
        next_ctr = ctr;
        case (dir)
            INC:     if (ctr != 2'd3) next_ctr = ctr + 2'd1;
            DEC:     if (ctr != 2'd0) next_ctr = ctr - 2'd1;
            default: next_ctr = ctr;
        endcase
    end

endmodule

// File: rtl/tournament_chooser.sv
// Tournament meta-predictor: per-index 2-bit choice counters picking local vs global,
// trained through a two-stage read-modify-write pipeline with S2 forwarding.
module tournament_chooser
    import prediction_pkg::*;
#(
    parameter chooser_ctr_t CTR_INIT = 2'b01
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_stalling,
    input  logic [INDEX_LEN-1:0] pred_index,
    input  logic                 local_guess,
    input  logic                 global_guess,
    output logic                 final_guess,
    output logic                 guess_global,
    output logic                 local_equal_global,
    input  logic                 resolve_valid,
    input  logic [INDEX_LEN-1:0] resolve_index,
    input  logic                 resolve_taken,
    input  logic                 resolve_predicted,
    output logic [INDEX_LEN-1:0] query_index,
    input  logic                 were_equal,
    input  logic                 had_guessed_global,
    output logic [31:0]          mispredict_count
);

    chooser_ctr_t ctr_table_q [TABLE_DEPTH];
    chooser_ctr_t ctr_table_d [TABLE_DEPTH];

    logic                 s1_valid_q, s1_valid_d;
    logic [INDEX_LEN-1:0] s1_index_q, s1_index_d;
    chooser_dir_t         s1_dir_q,   s1_dir_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [INDEX_LEN-1:0] s2_index_q, s2_index_d;
    chooser_ctr_t         s2_value_q, s2_value_d;

    logic [31:0]          mispredict_count_q, mispredict_count_d;

    chooser_ctr_t pred_ctr;
    chooser_ctr_t s1_ctr;
    chooser_ctr_t s1_next_ctr;
    logic         accept;

    // The pending S2 write wins over the table so neither path sees a stale counter.
    always_comb begin
        pred_ctr = ctr_table_q[pred_index];
        if (s2_valid_q && (s2_index_q == pred_index)) pred_ctr = s2_value_q;
        s1_ctr = ctr_table_q[s1_index_q];
        if (s2_valid_q && (s2_index_q == s1_index_q)) s1_ctr = s2_value_q;
    end

    assign guess_global       = (pred_ctr >= CHOOSER_GLOBAL_THRESH);
    assign final_guess        = guess_global ? global_guess : local_guess;
    assign local_equal_global = (local_guess == global_guess);
    assign query_index        = resolve_index;
    assign mispredict_count   = mispredict_count_q;
    assign accept             = resolve_valid && !is_stalling;

    sat_ctr2_update u_sat_ctr2_update (
        .ctr      (s1_ctr),
        .dir      (s1_dir_q),
        .next_ctr (s1_next_ctr)
    );

    always_comb begin
        s1_valid_d         = s1_valid_q;
        s1_index_d         = s1_index_q;
        s1_dir_d           = s1_dir_q;
        s2_valid_d         = s2_valid_q;
        s2_index_d         = s2_index_q;
        s2_value_d         = s2_value_q;
        mispredict_count_d = mispredict_count_q;
        ctr_table_d        = ctr_table_q;

        if (!is_stalling) begin
            s1_valid_d = resolve_valid;
            s1_index_d = resolve_index;
            s1_dir_d   = chooser_train_dir(were_equal, had_guessed_global,
                                           resolve_predicted, resolve_taken);
            s2_valid_d = s1_valid_q && (s1_dir_q != NONE);
            s2_index_d = s1_index_q;
            s2_value_d = s1_next_ctr;
            if (s2_valid_q) ctr_table_d[s2_index_q] = s2_value_q;
        end

        if (accept && (resolve_predicted != resolve_taken)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // NOTE: the counter table is a reset flop array so every entry starts at CTR_INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TABLE_DEPTH; i++) ctr_table_q[i] <= CTR_INIT;
            s1_valid_q         <= 1'b0;
            s1_index_q         <= '0;
            s1_dir_q           <= NONE;
            s2_valid_q         <= 1'b0;
            s2_index_q         <= '0;
            s2_value_q         <= CTR_INIT;
            mispredict_count_q <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            ctr_table_q        <= ctr_table_d;
            s1_valid_q         <= s1_valid_d;
            s1_index_q         <= s1_index_d;
            s1_dir_q           <= s1_dir_d;
            s2_valid_q         <= s2_valid_d;
            s2_index_q         <= s2_index_d;
            s2_value_q         <= s2_value_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_tournament_chooser.sv
// Directed testbench for tournament_chooser: inputs change and outputs are
// sampled around the falling edge, state advances on the rising edge.
module tb_tournament_chooser;
    import prediction_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 is_stalling;
    logic [INDEX_LEN-1:0] pred_index;
    logic                 local_guess;
    logic                 global_guess;
    logic                 final_guess;
    logic                 guess_global;
    logic                 local_equal_global;
    logic                 resolve_valid;
    logic [INDEX_LEN-1:0] resolve_index;
    logic                 resolve_taken;
    logic                 resolve_predicted;
    logic [INDEX_LEN-1:0] query_index;
    logic                 were_equal;
    logic                 had_guessed_global;
    logic [31:0]          mispredict_count;

    int          total;
    int          bad;
    logic [31:0] exp_count;

    tournament_chooser dut (
        .clk                (clk),
        .reset              (reset),
        .is_stalling        (is_stalling),
        .pred_index         (pred_index),
        .local_guess        (local_guess),
        .global_guess       (global_guess),
        .final_guess        (final_guess),
        .guess_global       (guess_global),
        .local_equal_global (local_equal_global),
        .resolve_valid      (resolve_valid),
        .resolve_index      (resolve_index),
        .resolve_taken      (resolve_taken),
        .resolve_predicted  (resolve_predicted),
        .query_index        (query_index),
        .were_equal         (were_equal),
        .had_guessed_global (had_guessed_global),
        .mispredict_count   (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Drives one resolution; the bench counts a mispredict only if it will be accepted.
    task automatic drive_resolve(input logic [INDEX_LEN-1:0] idx, input logic we,
                                 input logic hg, input logic pred, input logic taken);
        resolve_valid      = 1'b1;
        resolve_index      = idx;
        were_equal         = we;
        had_guessed_global = hg;
        resolve_predicted  = pred;
        resolve_taken      = taken;
        if (!is_stalling && (pred != taken)) exp_count = exp_count + 32'd1;
    endtask

    task automatic clear_resolve();
        resolve_valid = 1'b0;
    endtask

    // One isolated resolution, then enough cycles for it to land in the table.
    task automatic issue(input logic [INDEX_LEN-1:0] idx, input logic we,
                         input logic hg, input logic pred, input logic taken);
        next_cycle();
        drive_resolve(idx, we, hg, pred, taken);
        next_cycle();
        clear_resolve();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        next_cycle();
        pred_index    = 4'd5;
        local_guess   = 1'b1;
        global_guess  = 1'b0;
        resolve_index = 4'd7;
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL reset_guess_global: got %b want 0", guess_global);
        end
        total++;
        if (final_guess !== 1'b1) begin
            bad++; $display("FAIL reset_final_guess: got %b want 1", final_guess);
        end
        total++;
        if (local_equal_global !== 1'b0) begin
            bad++; $display("FAIL reset_local_equal_global: got %b want 0", local_equal_global);
        end
        total++;
        if (mispredict_count !== 32'd0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", mispredict_count);
        end
        total++;
        if (query_index !== 4'd7) begin
            bad++; $display("FAIL query_index: got %0d want 7", query_index);
        end
        global_guess = 1'b1;
        #1;
        total++;
        if (local_equal_global !== 1'b1) begin
            bad++; $display("FAIL local_equal_global_eq: got %b want 1", local_equal_global);
        end
        local_guess  = 1'b0;
        global_guess = 1'b1;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            pred_index = 4'(i);
            #1;
            total++;
            if (guess_global !== 1'b0 || final_guess !== 1'b0) begin
                bad++;
                $display("FAIL reset_table[%0d]: guess_global=%b final=%b want 0/0",
                         i, guess_global, final_guess);
            end
        end
    endtask

    task automatic test_back_to_back();
        local_guess  = 1'b0;
        global_guess = 1'b1;
        next_cycle();
        pred_index = 4'd5;
        drive_resolve(4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL b2b_before: got %b want 0", guess_global);
        end
        next_cycle();
        drive_resolve(4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL b2b_s1_only: got %b want 0", guess_global);
        end
        next_cycle();
        drive_resolve(4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b1 || final_guess !== 1'b1) begin
            bad++;
            $display("FAIL b2b_forward: guess_global=%b final=%b want 1/1", guess_global, final_guess);
        end
        next_cycle();
        clear_resolve();
        next_cycle();
        next_cycle();
        #1;
        total++;
        if (guess_global !== 1'b1) begin
            bad++; $display("FAIL b2b_table: got %b want 1", guess_global);
        end
        total++;
        if (mispredict_count !== exp_count) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d", mispredict_count, exp_count);
        end
        // Counter should be 3: one DEC leaves it global, a second returns it to local.
        issue(4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (guess_global !== 1'b1) begin
            bad++; $display("FAIL b2b_sat_high: got %b want 1", guess_global);
        end
        issue(4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL b2b_dec_to_local: got %b want 0", guess_global);
        end
    endtask

    task automatic test_saturate_low();
        pred_index = 4'd3;
        next_cycle();
        drive_resolve(4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive_resolve(4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive_resolve(4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        clear_resolve();
        next_cycle();
        next_cycle();
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL sat_low: got %b want 0", guess_global);
        end
        issue(4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL sat_low_inc1: got %b want 0", guess_global);
        end
        issue(4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b1 || final_guess !== 1'b1) begin
            bad++;
            $display("FAIL sat_low_inc2: guess_global=%b final=%b want 1/1", guess_global, final_guess);
        end
        total++;
        if (mispredict_count !== exp_count) begin
            bad++; $display("FAIL sat_low_count: got %0d want %0d", mispredict_count, exp_count);
        end
    endtask

    task automatic test_were_equal();
        pred_index = 4'd7;
        issue(4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL equal_no_update: got %b want 0", guess_global);
        end
        total++;
        if (mispredict_count !== exp_count) begin
            bad++; $display("FAIL equal_count_mispredict: got %0d want %0d", mispredict_count, exp_count);
        end
        issue(4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (mispredict_count !== exp_count) begin
            bad++; $display("FAIL equal_count_correct: got %0d want %0d", mispredict_count, exp_count);
        end
        issue(4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b1) begin
            bad++; $display("FAIL equal_then_inc: got %b want 1", guess_global);
        end
    endtask

    task automatic test_stall();
        pred_index = 4'd11;
        next_cycle();
        drive_resolve(4'd11, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        clear_resolve();
        next_cycle();
        is_stalling = 1'b1;
        drive_resolve(4'd11, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b1) begin
            bad++; $display("FAIL stall_forward_start: got %b want 1", guess_global);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            total++;
            if (guess_global !== 1'b1 || mispredict_count !== exp_count) begin
                bad++;
                $display("FAIL stall_hold[%0d]: guess_global=%b count=%0d want 1/%0d",
                         i, guess_global, mispredict_count, exp_count);
            end
        end
        is_stalling = 1'b0;
        clear_resolve();
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        total++;
        if (guess_global !== 1'b1 || mispredict_count !== exp_count) begin
            bad++;
            $display("FAIL stall_release: guess_global=%b count=%0d want 1/%0d",
                     guess_global, mispredict_count, exp_count);
        end
        // Counter should be 2 (no stalled INC accepted), so one DEC makes it local.
        issue(4'd11, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (guess_global !== 1'b0) begin
            bad++; $display("FAIL stall_no_accept: got %b want 0", guess_global);
        end
    endtask

    task automatic test_reset_midflight();
        pred_index = 4'd9;
        next_cycle();
        drive_resolve(4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        drive_resolve(4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        clear_resolve();
        #1;
        total++;
        if (guess_global !== 1'b1) begin
            bad++; $display("FAIL midflight_forward: got %b want 1", guess_global);
        end
        reset = 1'b0;
        #1;
        total++;
        if (guess_global !== 1'b0 || mispredict_count !== 32'd0) begin
            bad++;
            $display("FAIL midflight_async_clear: guess_global=%b count=%0d want 0/0",
                     guess_global, mispredict_count);
        end
        next_cycle();
        reset     = 1'b1;
        exp_count = 32'd0;
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        total++;
        if (guess_global !== 1'b0 || mispredict_count !== 32'd0) begin
            bad++;
            $display("FAIL midflight_discard: guess_global=%b count=%0d want 0/0",
                     guess_global, mispredict_count);
        end
        issue(4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (guess_global !== 1'b1 || mispredict_count !== exp_count) begin
            bad++;
            $display("FAIL midflight_reads_init: guess_global=%b count=%0d want 1/%0d",
                     guess_global, mispredict_count, exp_count);
        end
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        exp_count          = 32'd0;
        reset              = 1'b0;
        is_stalling        = 1'b0;
        pred_index         = '0;
        local_guess        = 1'b0;
        global_guess       = 1'b0;
        resolve_valid      = 1'b0;
        resolve_index      = '0;
        resolve_taken      = 1'b0;
        resolve_predicted  = 1'b0;
        were_equal         = 1'b0;
        had_guessed_global = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;

        test_reset();
        test_back_to_back();
        test_saturate_low();
        test_were_equal();
        test_stall();
        test_reset_midflight();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
